// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, nibble width and named 74181 function selects.
package alu_pkg;
    localparam int NIB_W = 4;
    localparam logic [3:0] ALU_S_ADD = 4'b1001;
    localparam logic [3:0] ALU_S_SUB = 4'b0110;
    localparam logic [3:0] ALU_S_XOR = 4'b0110;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_nibble_seq_slice.sv
// alu_nibble_seq_slice: combinational 74181-style 4-bit ALU slice (active-high data, active-low carry).
module alu_nibble_seq_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       ci_n,
    output logic [3:0] y,
    output logic       co_n,
    output logic       aeqb
);
    logic [3:0] t1, t2;
    logic [4:0] sum;
    always_comb begin
        t1   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        t2   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum  = {1'b0, t1} + {1'b0, t2} + {4'b0, ~ci_n};
        y    = m ? ~(t1 ^ t2) : sum[3:0];
        co_n = ~sum[4];
        aeqb = &y;
    end
endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: nibble-serial sequencer driving one 4-bit ALU slice, LSB nibble first.
// Optional ALU_SEQ_ZERO_EN adds a registered all-zero flag for the assembled result.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   op_ci_n,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   co_n_out,
    output logic                   a_eq_b_out,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_ci_n,
    input  logic [3:0]             alu_y,
    input  logic                   alu_co_n,
    input  logic                   alu_aeqb
`ifdef ALU_SEQ_ZERO_EN
    ,
    output logic                   zero_out
`endif
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    state_t state;
    logic [4*NIBBLES-1:0] a_q, b_q, res_next;
    logic [3:0] s_q;
    logic m_q, carry, eq;
    logic [IW-1:0] idx;
    logic last, run;
    always_comb begin
        run      = state == RUN;
        last     = idx == IW'(NIBBLES - 1);
        alu_a    = run ? a_q[NIB_W*idx +: NIB_W] : 4'h0;
        alu_b    = run ? b_q[NIB_W*idx +: NIB_W] : 4'h0;
        alu_s    = run ? s_q : 4'h0;
        alu_m    = run ? m_q : 1'b0;
        alu_ci_n = run ? carry : 1'b1;
        res_next = result;
        res_next[NIB_W*idx +: NIB_W] = alu_y;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            co_n_out   <= 1'b1;
            a_eq_b_out <= 1'b0;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= 4'h0;
            m_q        <= 1'b0;
            carry      <= 1'b1;
            eq         <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
            zero_out   <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    result <= res_next;
                    carry  <= alu_co_n;
                    eq     <= eq & alu_aeqb;
                    idx    <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        co_n_out   <= alu_co_n;
                        a_eq_b_out <= eq & alu_aeqb;
`ifdef ALU_SEQ_ZERO_EN
                        zero_out   <= res_next == '0;
`endif
                    end
                end
                default: begin
                    // IDLE and DONE accept a new op identically, so back-to-back ops need no bubble
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        s_q   <= op_s;
                        m_q   <= op_m;
                        carry <= op_ci_n;
                        eq    <= 1'b1;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: sequencer plus real slice, checked against a word-level 74181 function model.
module tb_alu_nibble_seq;
    import alu_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] op_a = '0, op_b = '0, result;
    logic [3:0] op_s = '0, alu_a, alu_b, alu_s, alu_y;
    logic op_m = 1'b0, op_ci_n = 1'b1;
    logic busy, done, co_n_out, a_eq_b_out, alu_m, alu_ci_n, alu_co_n, alu_aeqb;
`ifdef ALU_SEQ_ZERO_EN
    logic zero_out;
`endif
    int nchk = 0, nerr = 0, lat, bcnt;
    logic [3:0] trace [8];

    typedef struct {
        logic [15:0] a, b;
        logic [3:0]  s;
        logic        m, ci;
        logic [15:0] res;
        logic        co, eq;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .op_s(op_s),
        .op_m(op_m), .op_ci_n(op_ci_n), .busy(busy), .done(done), .result(result),
        .co_n_out(co_n_out), .a_eq_b_out(a_eq_b_out), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_m(alu_m), .alu_ci_n(alu_ci_n), .alu_y(alu_y),
        .alu_co_n(alu_co_n), .alu_aeqb(alu_aeqb)
`ifdef ALU_SEQ_ZERO_EN
        , .zero_out(zero_out)
`endif
    );

    alu_nibble_seq_slice slice (
        .a(alu_a), .b(alu_b), .s(alu_s), .m(alu_m), .ci_n(alu_ci_n),
        .y(alu_y), .co_n(alu_co_n), .aeqb(alu_aeqb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-word 74181 datasheet functions: arithmetic is x plus y plus carry, returns {a_eq_b, co_n, F}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic ci_n);
        logic [15:0] x, y, lf, f;
        logic [16:0] sum;
        case (s)
            4'h0: begin x = a;      y = 16'h0;  lf = ~a;       end
            4'h1: begin x = a | b;  y = 16'h0;  lf = ~(a | b); end
            4'h2: begin x = a | ~b; y = 16'h0;  lf = ~a & b;   end
            4'h3: begin x = 16'h0;  y = 16'hFFFF; lf = 16'h0;  end
            4'h4: begin x = a;      y = a & ~b; lf = ~(a & b); end
            4'h5: begin x = a | b;  y = a & ~b; lf = ~b;       end
            4'h6: begin x = a;      y = ~b;     lf = a ^ b;    end
            4'h7: begin x = a & ~b; y = 16'hFFFF; lf = a & ~b; end
            4'h8: begin x = a;      y = a & b;  lf = ~a | b;   end
            4'h9: begin x = a;      y = b;      lf = ~(a ^ b); end
            4'hA: begin x = a | ~b; y = a & b;  lf = b;        end
            4'hB: begin x = a & b;  y = 16'hFFFF; lf = a & b;  end
            4'hC: begin x = a;      y = a;      lf = 16'hFFFF; end
            4'hD: begin x = a | b;  y = a;      lf = a | ~b;   end
            4'hE: begin x = a | ~b; y = a;      lf = a | b;    end
            default: begin x = a;   y = 16'hFFFF; lf = a;      end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {16'h0, ~ci_n};
        f = m ? lf : sum[15:0];
        return {f == 16'hFFFF, ~sum[16], f};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic ci);
        @(negedge clk);
        op_a = a; op_b = b; op_s = s; op_m = m; op_ci_n = ci; start = 1'b1;
        lat = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            if (lat < 8) trace[lat] = alu_a;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 20);
    endtask

    initial begin
        logic [17:0] mo;
        logic [15:0] ra, rb;
        logic [3:0] rs;
        logic rm, rc;
        int pulses;
        vecs[0] = '{16'h1234, 16'h4321, ALU_S_ADD, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, ALU_S_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{16'h5A5A, 16'h5A5A, ALU_S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[3] = '{16'h5A5A, 16'h5A5B, ALU_S_SUB, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        vecs[4] = '{16'hF0F0, 16'h0FF0, ALU_S_XOR, 1'b1, 1'b1, 16'hFF00, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'hABCD, 4'hF,      1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_co_n", co_n_out, 1);
        chk("rst_aeqb", a_eq_b_out, 0);
        chk("rst_alu_ci_n", alu_ci_n, 1);
        chk("rst_alu_abs", {alu_a, alu_b, alu_s, 3'b0, alu_m}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].ci);
            chk($sformatf("v%0d_latency", i), lat, 5);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 4);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_co_n", i), co_n_out, vecs[i].co);
            chk($sformatf("v%0d_aeqb", i), a_eq_b_out, vecs[i].eq);
`ifdef ALU_SEQ_ZERO_EN
            chk($sformatf("v%0d_zero", i), zero_out, vecs[i].res == 16'h0);
`endif
            if (i == 4) begin
                chk("xor_alu_a0", trace[0], 4'h0);
                chk("xor_alu_a1", trace[1], 4'hF);
                chk("xor_alu_a2", trace[2], 4'h0);
                chk("xor_alu_a3", trace[3], 4'hF);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
            chk($sformatf("v%0d_result_held", i), result, vecs[i].res);
        end
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
            rm = 1'($urandom); rc = 1'($urandom);
            if (i < 4) rb = ra;
            mo = model(ra, rb, rs, rm, rc);
            run_op(ra, rb, rs, rm, rc);
            chk($sformatf("rnd%0d_result s=%h m=%b", i, rs, rm), result, mo[15:0]);
            chk($sformatf("rnd%0d_co_n", i), co_n_out, mo[16]);
            chk($sformatf("rnd%0d_aeqb", i), a_eq_b_out, mo[17]);
        end
        // start held high through RUN: one op, then the next accepted straight from DONE
        @(negedge clk);
        op_a = 16'h0102; op_b = 16'h0304; op_s = ALU_S_ADD; op_m = 1'b0; op_ci_n = 1'b1; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin op_a = 16'h1000; op_b = 16'h2000; end
        end while (!done && lat < 20);
        chk("held_latency", lat, 5);
        chk("held_result1", result, 16'h0406);
        @(negedge clk);
        chk("held_no_bubble_busy", busy, 1);
        chk("held_no_bubble_done", done, 0);
        start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        chk("held_latency2", lat, 4);
        chk("held_result2", result, 16'h3000);
        // reset in the second RUN cycle aborts at once with no done pulse
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; op_s = ALU_S_ADD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_co_n", co_n_out, 1);
        chk("abort_aeqb", a_eq_b_out, 0);
        chk("abort_alu_ci_n", alu_ci_n, 1);
        chk("abort_alu_a", alu_a, 0);
        pulses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
